// File: rtl/gate_bist_controller.sv
`default_nettype none
// ============================================================================
// Module   : gate_bist_controller
// Brief    : LFSR stimulus / MISR signature BIST controller for gate models.
// Revision : 1.0
// ============================================================================
module gate_bist_controller #(
  parameter int             IN_W      = 18,
  parameter int             OUT_W     = 10,
  parameter int             PATTERNS  = 256,
  parameter int             SETTLE    = 2,
  parameter logic [IN_W-1:0]  LFSR_TAPS = 18'h20400,
  parameter logic [IN_W-1:0]  LFSR_SEED = 18'h00001,
  parameter logic [OUT_W-1:0] MISR_TAPS = 10'h240,
  parameter logic [OUT_W-1:0] MISR_SEED = 10'h000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [OUT_W-1:0] exp_sig_i,
  input  logic [OUT_W-1:0] resp_i,
  output logic [IN_W-1:0]  stim_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [OUT_W-1:0] signature_o
);

  localparam int c_CNT_W = $clog2(PATTERNS + 1);
  localparam logic [IN_W-1:0]    c_SEED     = (LFSR_SEED == '0) ? IN_W'(1) : LFSR_SEED;
  localparam logic [c_CNT_W-1:0] c_PAT_LAST = c_CNT_W'(PATTERNS - 1);
  localparam logic [3:0]         c_SET_LAST = 4'((SETTLE > 0) ? SETTLE - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_SETTLE  = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // With no settle time every pattern is a single CAPTURE cycle.
  localparam state_t c_FIRST = (SETTLE == 0) ? S_CAPTURE : S_SETTLE;

  state_t             state_q, state_d;
  logic [IN_W-1:0]    stim_q, stim_d;
  logic [OUT_W-1:0]   sig_q, sig_d;
  logic [c_CNT_W-1:0] pat_q, pat_d;
  logic [3:0]         set_q, set_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [IN_W-1:0]    w_lfsr_next;
  logic [OUT_W-1:0]   w_misr_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      stim_q  <= '0;
      sig_q   <= MISR_SEED;
      pat_q   <= '0;
      set_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      sig_q   <= sig_d;
      pat_q   <= pat_d;
      set_q   <= set_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    stim_d      = stim_q;
    sig_d       = sig_q;
    pat_d       = pat_q;
    set_d       = set_q;
    done_d      = done_q;
    pass_d      = pass_q;
    w_lfsr_next = {stim_q[IN_W-2:0], ^(stim_q & LFSR_TAPS)};
    w_misr_next = {sig_q[OUT_W-2:0], ^(sig_q & MISR_TAPS)} ^ resp_i;

    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_LOAD;
      end
      S_LOAD: begin
        stim_d  = c_SEED;
        sig_d   = MISR_SEED;
        pat_d   = '0;
        set_d   = '0;
        state_d = c_FIRST;
      end
      S_SETTLE: begin
        if (set_q == c_SET_LAST) begin
          set_d   = '0;
          state_d = S_CAPTURE;
        end else begin
          set_d = set_q + 4'd1;
        end
      end
      S_CAPTURE: begin
        stim_d = w_lfsr_next;
        sig_d  = w_misr_next;
        pat_d  = pat_q + c_CNT_W'(1);
        if (pat_q == c_PAT_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (w_misr_next == exp_sig_i);
        end else begin
          state_d = c_FIRST;
        end
      end
      S_DONE: begin
        if (start_i) begin
          state_d = S_LOAD;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything, including a simultaneous start or capture.
    if (abort_i) begin
      state_d = S_IDLE;
      stim_d  = stim_q;
      sig_d   = sig_q;
      pat_d   = pat_q;
      set_d   = set_q;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end
  end

  assign stim_o      = stim_q;
  assign signature_o = sig_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign busy_o      = (state_q == S_LOAD) || (state_q == S_SETTLE) || (state_q == S_CAPTURE);

endmodule
`default_nettype wire

// File: tb/tb_gate_bist_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_bist_controller
// Brief    : Directed self-checking bench for gate_bist_controller.
// Revision : 1.0
// ============================================================================
module tb_gate_bist_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // u_a: SETTLE=0 PATTERNS=3; u_b: SETTLE=1 PATTERNS=2;
  // u_c: SETTLE=2 PATTERNS=4; u_d: SETTLE=2 PATTERNS=256 against a gate model.
  logic        start_a = 0, abort_a = 0, busy_a, done_a, pass_a;
  logic [9:0]  exp_a = 0, resp_a = 0, sig_a;
  logic [17:0] stim_a;
  logic        start_b = 0, abort_b = 0, busy_b, done_b, pass_b;
  logic [9:0]  exp_b = 0, resp_b = 0, sig_b;
  logic [17:0] stim_b;
  logic        start_c = 0, abort_c = 0, busy_c, done_c, pass_c;
  logic [9:0]  exp_c = 0, resp_c = 0, sig_c;
  logic [17:0] stim_c;
  logic        start_d = 0, abort_d = 0, busy_d, done_d, pass_d;
  logic [9:0]  exp_d = 0, sig_d;
  logic [9:0]  w_resp_d;
  logic [17:0] stim_d;
  logic        flip_en = 0;
  logic [17:0] stim100 = 0;

  gate_bist_controller #(.PATTERNS(3), .SETTLE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .abort_i(abort_a), .exp_sig_i(exp_a),
    .resp_i(resp_a), .stim_o(stim_a), .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a),
    .signature_o(sig_a));
  gate_bist_controller #(.PATTERNS(2), .SETTLE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .abort_i(abort_b), .exp_sig_i(exp_b),
    .resp_i(resp_b), .stim_o(stim_b), .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b),
    .signature_o(sig_b));
  gate_bist_controller #(.PATTERNS(4), .SETTLE(2)) u_c (
    .clk(clk), .rst_n(rst_n), .start_i(start_c), .abort_i(abort_c), .exp_sig_i(exp_c),
    .resp_i(resp_c), .stim_o(stim_c), .busy_o(busy_c), .done_o(done_c), .pass_o(pass_c),
    .signature_o(sig_c));
  gate_bist_controller #(.PATTERNS(256), .SETTLE(2)) u_d (
    .clk(clk), .rst_n(rst_n), .start_i(start_d), .abort_i(abort_d), .exp_sig_i(exp_d),
    .resp_i(w_resp_d), .stim_o(stim_d), .busy_o(busy_d), .done_o(done_d), .pass_o(pass_d),
    .signature_o(sig_d));

  // Stand-in 18-in/10-out combinational gate model.
  function automatic logic [9:0] gate_fn(input logic [17:0] s);
    logic [9:0] r;
    r[0] = s[0] & s[1];
    r[1] = s[2] | s[3];
    r[2] = s[4] ^ s[5] ^ s[6];
    r[3] = ~(s[7] & s[8]);
    r[4] = ~(s[9] | s[10]);
    r[5] = (s[11] & s[12]) | s[13];
    r[6] = s[14] ^ s[15];
    r[7] = s[16] & ~s[17];
    r[8] = ^s;
    r[9] = (&s[3:0]) | s[17];
    return r;
  endfunction

  assign w_resp_d = gate_fn(stim_d) ^ {9'b0, flip_en && (stim_d == stim100)};

  // Reference signature; flip_pat selects a pattern whose bit 0 is inverted (-1 = none).
  function automatic logic [9:0] ref_sig(input int flip_pat);
    logic [17:0] l;
    logic [9:0]  s, r;
    l = 18'h00001;
    s = 10'h000;
    for (int k = 0; k < 256; k++) begin
      r = gate_fn(l);
      if (k == flip_pat) r[0] = ~r[0];
      s = {s[8:0], ^(s & 10'h240)} ^ r;
      l = {l[16:0], ^(l & 18'h20400)};
    end
    return s;
  endfunction

  function automatic logic [17:0] ref_stim(input int pat);
    logic [17:0] l;
    l = 18'h00001;
    for (int k = 0; k < pat; k++) l = {l[16:0], ^(l & 18'h20400)};
    return l;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the caller in cycle 1 (the LOAD cycle) of the run.
  task automatic pulse_start(input int which);
    @(posedge clk);
    #1;
    case (which)
      0: start_a = 1'b1;
      1: start_b = 1'b1;
      2: start_c = 1'b1;
      default: start_d = 1'b1;
    endcase
    tick(1);
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    start_d = 1'b0;
  endtask

  task automatic wait_done_d(output int n);
    n = 0;
    while (!done_d && n < 2000) begin
      tick(1);
      n++;
    end
  endtask

  logic [9:0] good_sig, bad_sig;
  int         lat;

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst stim",   32'(stim_c), 0);
    check("rst sig",    32'(sig_c),  0);
    check("rst busy",   32'(busy_c), 0);
    check("rst done",   32'(done_c), 0);
    check("rst pass",   32'(pass_c), 0);
    tick(2);
    rst_n = 1'b1;

    // T1: asynchronous reset in the middle of SETTLE.
    resp_c = 10'h3FF;
    pulse_start(2);
    tick(4);
    check("t1 pre stim", 32'(stim_c), 32'h2);
    check("t1 pre sig",  32'(sig_c),  32'h3FF);
    check("t1 pre busy", 32'(busy_c), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t1 stim", 32'(stim_c), 0);
    check("t1 sig",  32'(sig_c),  0);
    check("t1 busy", 32'(busy_c), 0);
    check("t1 done", 32'(done_c), 0);
    tick(1);
    rst_n = 1'b1;

    // T2: LFSR sequence with SETTLE=0.
    pulse_start(0);
    check("t2 busy c1", 32'(busy_a), 1);
    tick(1); check("t2 stim c2", 32'(stim_a), 32'h1);
    tick(1); check("t2 stim c3", 32'(stim_a), 32'h2);
    tick(1); check("t2 stim c4", 32'(stim_a), 32'h4);
    check("t2 done c4", 32'(done_a), 0);
    tick(1);
    check("t2 done c5", 32'(done_a), 1);
    check("t2 busy c5", 32'(busy_a), 0);
    check("t2 pass",    32'(pass_a), 1);
    check("t2 stim c5", 32'(stim_a), 32'h8);

    // T3: MISR with resp=3FF held, then a failing expected value and a SETTLE glitch.
    resp_b = 10'h3FF;
    exp_b  = 10'h001;
    pulse_start(1);
    tick(3); check("t3 sig c4", 32'(sig_b), 32'h3FF);
    tick(2);
    check("t3 done", 32'(done_b), 1);
    check("t3 sig",  32'(sig_b),  32'h001);
    check("t3 pass", 32'(pass_b), 1);
    exp_b = 10'h000;
    pulse_start(1);
    check("t3b done clr", 32'(done_b), 0);
    check("t3b pass clr", 32'(pass_b), 0);
    tick(1); check("t3b sig seed", 32'(sig_b), 0);
    tick(2); resp_b = 10'h155;
    tick(1); resp_b = 10'h3FF;
    tick(1);
    check("t3b done", 32'(done_b), 1);
    check("t3b sig",  32'(sig_b),  32'h001);
    check("t3b pass", 32'(pass_b), 0);

    // T4: latency with an ignored start while busy.
    resp_c = 10'h000;
    exp_c  = 10'h000;
    pulse_start(2);
    check("t4 busy c1", 32'(busy_c), 1);
    tick(5); start_c = 1'b1;
    tick(1); start_c = 1'b0;
    tick(6);
    check("t4 done c13", 32'(done_c), 0);
    check("t4 busy c13", 32'(busy_c), 1);
    tick(1);
    check("t4 done c14", 32'(done_c), 1);
    check("t4 busy c14", 32'(busy_c), 0);
    check("t4 pass",     32'(pass_c), 1);
    check("t4 stim",     32'(stim_c), 32'h10);

    // T5: abort (with start) in CAPTURE of pattern 2, then a clean rerun.
    resp_c = 10'h3FF;
    exp_c  = 10'h005;
    pulse_start(2);
    tick(9);
    abort_c = 1'b1;
    start_c = 1'b1;
    tick(1);
    abort_c = 1'b0;
    start_c = 1'b0;
    check("t5 busy", 32'(busy_c), 0);
    check("t5 done", 32'(done_c), 0);
    check("t5 pass", 32'(pass_c), 0);
    check("t5 stim hold", 32'(stim_c), 32'h4);
    check("t5 sig hold",  32'(sig_c),  32'h001);
    tick(3);
    check("t5 idle busy", 32'(busy_c), 0);
    check("t5 idle done", 32'(done_c), 0);
    pulse_start(2);
    tick(1);
    check("t5 rerun stim", 32'(stim_c), 32'h1);
    check("t5 rerun sig",  32'(sig_c),  0);
    tick(12);
    check("t5 rerun done", 32'(done_c), 1);
    check("t5 rerun sig2", 32'(sig_c),  32'h005);
    check("t5 rerun pass", 32'(pass_c), 1);

    // T6: 256 patterns against the gate model, then with one flipped output bit.
    good_sig = ref_sig(-1);
    bad_sig  = ref_sig(100);
    stim100  = ref_stim(100);
    exp_d    = good_sig;
    pulse_start(3);
    wait_done_d(lat);
    check("t6 done",    32'(done_d), 1);
    check("t6 latency", 32'(lat),    769);
    check("t6 sig",     32'(sig_d),  32'(good_sig));
    check("t6 pass",    32'(pass_d), 1);
    flip_en = 1'b1;
    pulse_start(3);
    wait_done_d(lat);
    check("t6f done", 32'(done_d), 1);
    check("t6f sig",  32'(sig_d),  32'(bad_sig));
    check("t6f pass", 32'(pass_d), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
